// File: rtl/vesa_timing_pkg.sv
// Shared definitions for the VESA timing generators: FSM encoding, axis indices
// and the 720p60 reset-default timing.
package vesa_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vt_state_e;

    localparam int AX_H = 0;
    localparam int AX_V = 1;

    localparam int VT_DEF_H_ACT  = 1280;
    localparam int VT_DEF_H_FP   = 48;
    localparam int VT_DEF_H_SYNC = 32;
    localparam int VT_DEF_H_BP   = 240;
    localparam int VT_DEF_V_ACT  = 720;
    localparam int VT_DEF_V_FP   = 3;
    localparam int VT_DEF_V_SYNC = 5;
    localparam int VT_DEF_V_BP   = 20;
    localparam bit VT_DEF_HS_POL = 1'b1;
    localparam bit VT_DEF_VS_POL = 1'b1;

    // Drive the active level only inside the sync region.
    function automatic logic sync_level(input logic in_sync, input logic pol);
        return in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vesa_axis_cnt.sv
// One timing axis: position counter with wrap plus active/sync region decode
// from the act/fp/sync/bp fields (line order: active, FP, sync, BP).
module vesa_axis_cnt
    import vesa_timing_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] act,
    input  logic [CNT_W-1:0] fp,
    input  logic [CNT_W-1:0] sync,
    input  logic [CNT_W-1:0] bp,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             active,
    output logic             in_sync
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] sync_start;
    logic [CNT_W-1:0] sync_end;
    logic [CNT_W-1:0] last_pos;

    // Accepted configurations keep the total within CNT_W, so these cannot wrap.
    assign sync_start = act + fp;
    assign sync_end   = sync_start + sync;
    assign last_pos   = sync_end + bp - CNT_W'(1);

    assign last    = (cnt_reg == last_pos);
    assign active  = (cnt_reg < act);
    assign in_sync = (cnt_reg >= sync_start) && (cnt_reg < sync_end);
    assign cnt     = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= last ? '0 : cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vesa_timing_gen_prog.sv
// Runtime-programmable VESA/CEA timing generator. Configuration is staged and
// committed only at frame boundaries (or while idle) so mode switches never tear.
module vesa_timing_gen_prog
    import vesa_timing_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_H_ACT  = VT_DEF_H_ACT,
    parameter int DEF_H_FP   = VT_DEF_H_FP,
    parameter int DEF_H_SYNC = VT_DEF_H_SYNC,
    parameter int DEF_H_BP   = VT_DEF_H_BP,
    parameter int DEF_V_ACT  = VT_DEF_V_ACT,
    parameter int DEF_V_FP   = VT_DEF_V_FP,
    parameter int DEF_V_SYNC = VT_DEF_V_SYNC,
    parameter int DEF_V_BP   = VT_DEF_V_BP,
    parameter bit DEF_HS_POL = VT_DEF_HS_POL,
    parameter bit DEF_VS_POL = VT_DEF_VS_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_h_act,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_act,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_valid,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             sof,
    output logic             eol
);

    localparam logic [CNT_W+1:0] TOT_MAX = {2'b00, {CNT_W{1'b1}}};

    vt_state_e state_reg;
    logic      pending_reg;
    logic      err_reg;
    logic      running;
    logic      frame_end;
    logic      commit;
    logic      cfg_ok;
    logic      cfg_accept;

    logic [1:0][CNT_W-1:0] cfg_act, cfg_fp, cfg_sync, cfg_bp;
    logic [1:0][CNT_W-1:0] ax_cnt;
    logic [1:0]            cfg_pol, axis_ok, ax_inc, ax_last, ax_active, ax_in_sync, ax_pol;

    logic             hsync_reg, vsync_reg, de_reg, frame_valid_reg, sof_reg, eol_reg;
    logic [CNT_W-1:0] h_count_reg, v_count_reg;

    assign cfg_act  = {cfg_v_act,  cfg_h_act};
    assign cfg_fp   = {cfg_v_fp,   cfg_h_fp};
    assign cfg_sync = {cfg_v_sync, cfg_h_sync};
    assign cfg_bp   = {cfg_v_bp,   cfg_h_bp};
    assign cfg_pol  = {cfg_vs_pol, cfg_hs_pol};

    assign running    = (state_reg != ST_IDLE);
    assign ax_inc     = {running & ax_last[AX_H], running};
    assign frame_end  = running & ax_last[AX_H] & ax_last[AX_V];
    assign commit     = pending_reg & (frame_end | (state_reg == ST_IDLE));
    assign cfg_ok     = &axis_ok;
    assign cfg_accept = cfg_valid & cfg_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [CNT_W-1:0] D_ACT  = CNT_W'((gi == AX_H) ? DEF_H_ACT  : DEF_V_ACT);
            localparam logic [CNT_W-1:0] D_FP   = CNT_W'((gi == AX_H) ? DEF_H_FP   : DEF_V_FP);
            localparam logic [CNT_W-1:0] D_SYNC = CNT_W'((gi == AX_H) ? DEF_H_SYNC : DEF_V_SYNC);
            localparam logic [CNT_W-1:0] D_BP   = CNT_W'((gi == AX_H) ? DEF_H_BP   : DEF_V_BP);
            localparam bit               D_POL  = (gi == AX_H) ? DEF_HS_POL : DEF_VS_POL;

            logic [CNT_W+1:0] tot;
            logic [CNT_W-1:0] act_reg, fp_reg, sync_reg, bp_reg;
            logic [CNT_W-1:0] stg_act_reg, stg_fp_reg, stg_sync_reg, stg_bp_reg;
            logic             pol_reg, stg_pol_reg;

            // Two guard bits so the four-term sum can never wrap before the range test.
            assign tot = {2'b00, cfg_act[gi]} + {2'b00, cfg_fp[gi]}
                       + {2'b00, cfg_sync[gi]} + {2'b00, cfg_bp[gi]};
            assign axis_ok[gi] = (cfg_act[gi] != '0) && (cfg_sync[gi] != '0) && (tot <= TOT_MAX);
            assign ax_pol[gi]  = pol_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    act_reg      <= D_ACT;
                    fp_reg       <= D_FP;
                    sync_reg     <= D_SYNC;
                    bp_reg       <= D_BP;
                    pol_reg      <= D_POL;
                    stg_act_reg  <= '0;
                    stg_fp_reg   <= '0;
                    stg_sync_reg <= '0;
                    stg_bp_reg   <= '0;
                    stg_pol_reg  <= 1'b0;
                end else begin
                    if (commit) begin
                        act_reg  <= stg_act_reg;
                        fp_reg   <= stg_fp_reg;
                        sync_reg <= stg_sync_reg;
                        bp_reg   <= stg_bp_reg;
                        pol_reg  <= stg_pol_reg;
                    end
                    if (cfg_accept) begin
                        stg_act_reg  <= cfg_act[gi];
                        stg_fp_reg   <= cfg_fp[gi];
                        stg_sync_reg <= cfg_sync[gi];
                        stg_bp_reg   <= cfg_bp[gi];
                        stg_pol_reg  <= cfg_pol[gi];
                    end
                end
            end

            vesa_axis_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (~running),
                .inc     (ax_inc[gi]),
                .act     (act_reg),
                .fp      (fp_reg),
                .sync    (sync_reg),
                .bp      (bp_reg),
                .cnt     (ax_cnt[gi]),
                .last    (ax_last[gi]),
                .active  (ax_active[gi]),
                .in_sync (ax_in_sync[gi])
            );
        end
    endgenerate

    // A new value accepted in the commit cycle stays pending behind the one being applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (cfg_accept) begin
                pending_reg <= 1'b1;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end
            if (cfg_valid) begin
                err_reg <= ~cfg_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) state_reg <= frame_end ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (frame_end) begin
                        state_reg <= enable ? ST_RUN : ST_IDLE;
                    end else if (enable) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg       <= ~DEF_HS_POL;
            vsync_reg       <= ~DEF_VS_POL;
            de_reg          <= 1'b0;
            frame_valid_reg <= 1'b0;
            sof_reg         <= 1'b0;
            eol_reg         <= 1'b0;
            h_count_reg     <= '0;
            v_count_reg     <= '0;
        end else begin
            hsync_reg       <= sync_level(running & ax_in_sync[AX_H], ax_pol[AX_H]);
            vsync_reg       <= sync_level(running & ax_in_sync[AX_V], ax_pol[AX_V]);
            de_reg          <= running & ax_active[AX_H] & ax_active[AX_V];
            frame_valid_reg <= running;
            sof_reg         <= running && (ax_cnt[AX_H] == '0) && (ax_cnt[AX_V] == '0);
            eol_reg         <= running & ax_last[AX_H];
            h_count_reg     <= ax_cnt[AX_H];
            v_count_reg     <= ax_cnt[AX_V];
        end
    end

    assign cfg_pending = pending_reg;
    assign cfg_err     = err_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign frame_valid = frame_valid_reg;
    assign sof         = sof_reg;
    assign eol         = eol_reg;
    assign h_count     = h_count_reg;
    assign v_count     = v_count_reg;

endmodule

// File: tb/tb_vesa_timing_gen_prog.sv
// Scoreboard bench: stimulus queues the hand-computed shape of each frame it expects;
// a monitor measures every frame the DUT produces and compares it against the queue.
module tb_vesa_timing_gen_prog;

    localparam int W = 16;
    localparam int TMO = 3000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_h_act = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
    logic [W-1:0] cfg_v_act = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
    logic         cfg_hs_pol = 1'b0, cfg_vs_pol = 1'b0;
    logic         cfg_pending, cfg_err, hsync, vsync, de, frame_valid, sof, eol;
    logic [W-1:0] h_count, v_count;

    typedef struct {
        int cycles;
        int lines;
        int de_cnt;
        int hs_hi;
        int vs_hi;
        int hs_start;
        int vs_start;
        int last_h;
        int last_v;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    frame_t fr_a, fr_b, fr_c, fr_d;
    bit     in_frame = 1'b0;
    bit     hs_seen, vs_seen;
    logic   sof_hs, sof_vs;
    int     fnum = 0;
    int     n_pass = 0;
    int     n_total = 0;

    always #5 clk = ~clk;

    // Small default mode keeps whole frames short: H 8/2/3/2, V 4/1/2/1, active-high syncs.
    vesa_timing_gen_prog #(
        .CNT_W(W), .DEF_H_ACT(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
        .DEF_V_ACT(4), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1),
        .DEF_HS_POL(1'b1), .DEF_VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_valid(frame_valid),
        .h_count(h_count), .v_count(v_count), .sof(sof), .eol(eol)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, TMO);
    endtask

    function automatic frame_t mk(input int cyc, input int ln, input int dec, input int hs,
                                  input int vs, input int hss, input int vss,
                                  input int lh, input int lv);
        frame_t f;
        f.cycles = cyc; f.lines = ln; f.de_cnt = dec; f.hs_hi = hs; f.vs_hi = vs;
        f.hs_start = hss; f.vs_start = vss; f.last_h = lh; f.last_v = lv;
        return f;
    endfunction

    task automatic finish_frame();
        frame_t e;
        fnum++;
        if (exp_q.size() == 0) begin
            chk($sformatf("f%0d_unexpected_frame", fnum), 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("f%0d_cycles", fnum),   cur.cycles,   e.cycles);
            chk($sformatf("f%0d_lines", fnum),    cur.lines,    e.lines);
            chk($sformatf("f%0d_de", fnum),       cur.de_cnt,   e.de_cnt);
            chk($sformatf("f%0d_hs_hi", fnum),    cur.hs_hi,    e.hs_hi);
            chk($sformatf("f%0d_vs_hi", fnum),    cur.vs_hi,    e.vs_hi);
            chk($sformatf("f%0d_hs_start", fnum), cur.hs_start, e.hs_start);
            chk($sformatf("f%0d_vs_start", fnum), cur.vs_start, e.vs_start);
            chk($sformatf("f%0d_last_h", fnum),   cur.last_h,   e.last_h);
            chk($sformatf("f%0d_last_v", fnum),   cur.last_v,   e.last_v);
        end
        $display("frame %0d: cycles=%0d lines=%0d de=%0d hs_hi=%0d vs_hi=%0d hs_start=%0d vs_start=%0d",
                 fnum, cur.cycles, cur.lines, cur.de_cnt, cur.hs_hi, cur.vs_hi,
                 cur.hs_start, cur.vs_start);
        in_frame = 1'b0;
    endtask

    // Monitor: a frame runs from a sof until the next sof or the fall of frame_valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (in_frame && (sof || !frame_valid)) finish_frame();
            if (sof && frame_valid) begin
                in_frame = 1'b1;
                cur = '{default: 0};
                cur.hs_start = -1;
                cur.vs_start = -1;
                hs_seen = 1'b0;
                vs_seen = 1'b0;
                sof_hs = hsync;
                sof_vs = vsync;
            end
            if (in_frame) begin
                cur.cycles++;
                cur.de_cnt += int'(de);
                cur.hs_hi  += int'(hsync);
                cur.vs_hi  += int'(vsync);
                if (!hs_seen && hsync != sof_hs) begin
                    hs_seen = 1'b1;
                    cur.hs_start = int'(h_count);
                end
                if (!vs_seen && vsync != sof_vs) begin
                    vs_seen = 1'b1;
                    cur.vs_start = int'(v_count);
                end
                if (eol) begin
                    cur.lines++;
                    cur.last_h = int'(h_count);
                    cur.last_v = int'(v_count);
                end
            end
        end
    end

    // 0: output at (v,h) with h<0 as don't-care; 1: frame_valid==a; 2: cfg_pending==a;
    // 3: sof; 4: eol on line a.
    function automatic bit cond(input int which, input int a, input int b);
        case (which)
            0: return frame_valid && int'(v_count) == a && (b < 0 || int'(h_count) == b);
            1: return int'(frame_valid) == a;
            2: return int'(cfg_pending) == a;
            3: return sof == 1'b1;
            default: return eol && int'(v_count) == a;
        endcase
    endfunction

    task automatic wait_cond(input int which, input int a, input int b);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cond(which, a, b) && n < TMO);
        if (n >= TMO) fail_now($sformatf("wait_cond_%0d_%0d_%0d", which, a, b));
    endtask

    task automatic send_cfg(input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input bit hp, input bit vp);
        cfg_h_act = W'(ha); cfg_h_fp = W'(hf); cfg_h_sync = W'(hs); cfg_h_bp = W'(hb);
        cfg_v_act = W'(va); cfg_v_fp = W'(vf); cfg_v_sync = W'(vs); cfg_v_bp = W'(vb);
        cfg_hs_pol = hp; cfg_vs_pol = vp;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        $display("cfg H %0d/%0d/%0d/%0d V %0d/%0d/%0d/%0d pol %0d/%0d -> pending=%0d err=%0d",
                 ha, hf, hs, hb, va, vf, vs, vb, hp, vp, cfg_pending, cfg_err);
    endtask

    initial begin
        // cycles, lines, de, hsync-high cycles, vsync-high cycles, hs start h, vs start v, last h, last v
        fr_a = mk(120, 8, 32, 24, 30, 10, 5, 14, 7);  // 8/2/3/2 x 4/1/2/1, pol 1/1
        fr_b = mk(96,  8, 18, 80, 84,  7, 5, 11, 7);  // 6/1/2/3 x 3/2/1/2, pol 0/0
        fr_c = mk(35,  5,  8,  5, 28,  5, 3,  6, 4);  // 4/1/1/1 x 2/1/1/1, pol 1/0
        fr_d = mk(70,  7, 15, 56, 10,  7, 4,  9, 6);  // 5/2/2/1 x 3/1/1/2, pol 0/1

        repeat (3) @(posedge clk);
        #1;
        chk("rst_frame_valid", int'(frame_valid), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_hsync", int'(hsync), 0);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_h_count", int'(h_count), 0);
        chk("rst_v_count", int'(v_count), 0);
        chk("rst_sof", int'(sof), 0);
        chk("rst_eol", int'(eol), 0);
        chk("rst_pending", int'(cfg_pending), 0);
        chk("rst_err", int'(cfg_err), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_frame_valid", int'(frame_valid), 0);

        // Frame 1 default, B staged mid-frame, rejected cfg leaves B pending.
        exp_q.push_back(fr_a);
        enable = 1'b1;
        wait_cond(0, 2, -1);
        send_cfg(6, 1, 2, 3, 3, 2, 1, 2, 1'b0, 1'b0);
        chk("pending_after_b", int'(cfg_pending), 1);
        chk("err_after_b", int'(cfg_err), 0);
        exp_q.push_back(fr_b);
        send_cfg(6, 1, 0, 3, 3, 2, 1, 2, 1'b0, 1'b0);
        chk("err_bad_hsync", int'(cfg_err), 1);
        chk("pending_bad_hsync", int'(cfg_pending), 1);
        wait_cond(2, 0, 0);

        // Frame 2 (B): stage C, then stage D exactly in the commit cycle.
        wait_cond(0, 1, -1);
        send_cfg(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0);
        chk("err_cleared", int'(cfg_err), 0);
        chk("pending_c", int'(cfg_pending), 1);
        exp_q.push_back(fr_c);
        wait_cond(0, 7, 10);
        send_cfg(5, 2, 2, 1, 3, 1, 1, 2, 1'b0, 1'b1);
        chk("pending_coincident", int'(cfg_pending), 1);
        exp_q.push_back(fr_d);
        wait_cond(0, 1, -1);
        chk("pending_during_c", int'(cfg_pending), 1);
        wait_cond(2, 0, 0);

        // Frame 4 (D): drop enable mid-frame, frame completes then IDLE.
        wait_cond(0, 2, -1);
        enable = 1'b0;
        wait_cond(4, 6, 0);
        chk("fv_last_pixel", int'(frame_valid), 1);
        @(posedge clk);
        #1;
        chk("fv_fall", int'(frame_valid), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_h_count", int'(h_count), 0);
        chk("idle_v_count", int'(v_count), 0);
        chk("idle_de", int'(de), 0);
        chk("idle_hsync_low_pol", int'(hsync), 1);
        chk("idle_vsync_high_pol", int'(vsync), 0);

        // Re-enable inside DRAIN: the next frame follows without a gap.
        exp_q.push_back(fr_d);
        exp_q.push_back(fr_d);
        enable = 1'b1;
        wait_cond(0, 1, -1);
        enable = 1'b0;
        wait_cond(0, 4, -1);
        enable = 1'b1;
        chk("fv_in_drain", int'(frame_valid), 1);
        wait_cond(3, 0, 0);
        wait_cond(0, 2, -1);
        enable = 1'b0;
        wait_cond(1, 0, 0);

        // Reset mid-frame: outputs return to reset values at once, defaults restored.
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        wait_cond(0, 3, 4);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("midrst_frame_valid", int'(frame_valid), 0);
        chk("midrst_h_count", int'(h_count), 0);
        chk("midrst_v_count", int'(v_count), 0);
        chk("midrst_hsync", int'(hsync), 0);
        chk("midrst_de", int'(de), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(fr_a);
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_cond(1, 1, 0);
        chk("restart_sof", int'(sof), 1);
        chk("restart_h", int'(h_count), 0);
        chk("restart_v", int'(v_count), 0);
        wait_cond(0, 3, -1);
        enable = 1'b0;
        wait_cond(1, 0, 0);

        // Config written while IDLE commits on the following cycle.
        repeat (3) @(posedge clk);
        #1;
        send_cfg(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0);
        chk("idle_pending_set", int'(cfg_pending), 1);
        @(posedge clk);
        #1;
        chk("idle_pending_clear", int'(cfg_pending), 0);
        exp_q.push_back(fr_c);
        enable = 1'b1;
        wait_cond(0, 1, -1);
        enable = 1'b0;
        wait_cond(1, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
